// File: rtl/nlc_sample_feeder.sv
// Rate-adapting feeder: buffers ADC samples in a small FIFO and issues them
// one at a time to the NLC core, counting overflow drops and response timeouts.
module nlc_sample_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       adc_valid,
    input  logic [20:0]                adc_data,
    output logic [20:0]                x_adc,
    output logic                       srdyi,
    input  logic                       srdyo,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           timeout_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // Handshake: srdyi is a one-cycle start strobe with x_adc held until the
    // next issue; srdyo is a one-cycle done strobe honoured only in ST_WAIT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [20:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [WAIT_W-1:0] wait_cnt;
    logic              pop, push, drop, timeout_hit;

    assign pop         = (state == ST_IDLE) && (level != '0);
    // A full FIFO still accepts a sample when the same cycle pops the head.
    assign push        = adc_valid && !((level == LVL_W'(DEPTH)) && !pop);
    assign drop        = adc_valid && !push;
    assign timeout_hit = (state == ST_WAIT) && !srdyo &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign fifo_level  = level;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pop) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (srdyo || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        srdyi = (state == ST_ISSUE);
        busy  = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= adc_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            x_adc       <= '0;
            wait_cnt    <= '0;
            drop_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                x_adc  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (state == ST_ISSUE)
                wait_cnt <= '0;
            else if ((state == ST_WAIT) && !srdyo && !timeout_hit)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
            if (timeout_hit && (timeout_cnt != '1))
                timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nlc_sample_feeder.sv
// Self-checking bench for nlc_sample_feeder: directed scenarios plus random
// traffic, compared every cycle against a queue-based transaction model.
module tb_nlc_sample_feeder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1023;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              adc_valid = 1'b0;
    logic [20:0]       adc_data = '0;
    logic              srdyo = 1'b0;
    logic [20:0]       x_adc;
    logic              srdyi;
    logic              busy;
    logic [3:0]        fifo_level;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  timeout_cnt;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    nlc_sample_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
        .x_adc(x_adc), .srdyi(srdyi), .srdyo(srdyo), .busy(busy),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    // reference model: buffered samples, one in-flight sample and its age
    logic [20:0]      m_q[$];
    logic [20:0]      exp_q[$];
    logic [20:0]      m_x = '0;
    bit               m_inflight = 0;
    int               m_age = 0;
    logic [CNT_W-1:0] m_drop = '0;
    logic [CNT_W-1:0] m_tmo = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [20:0] d, input logic r, input logic rst);
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_inflight = 0;
            m_age = 0;
            m_x = '0;
            m_drop = '0;
            m_tmo = '0;
            return;
        end
        if (m_inflight) begin
            // the done strobe counts only once the start strobe has passed
            if (m_age >= 1 && r) m_inflight = 0;
            else if (m_age == TIMEOUT) begin
                m_inflight = 0;
                if (m_tmo != '1) m_tmo = m_tmo + 1'b1;
            end else m_age++;
        end else if (m_q.size() > 0) begin
            m_x = m_q.pop_front();
            m_inflight = 1;
            m_age = 0;
        end
        if (v) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
                exp_q.push_back(d);
            end else if (m_drop != '1) m_drop = m_drop + 1'b1;
        end
    endtask

    task automatic compare_outputs();
        logic [20:0] e;
        check("srdyi", 32'(srdyi), 32'(m_inflight && m_age == 0));
        check("busy", 32'(busy), 32'(m_inflight));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("x_adc", 32'(x_adc), 32'(m_x));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
        if (srdyi === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_issue", 32'(1), 32'(0));
            else begin
                e = exp_q.pop_front();
                check("sb_order", 32'(x_adc), 32'(e));
            end
        end
    endtask

    // driver: one clock cycle of stimulus, model update, and output compare
    task automatic cycle(input logic v, input logic [20:0] d, input logic r, input logic rst);
        @(negedge clk);
        adc_valid = v;
        adc_data  = d;
        srdyo     = r;
        reset     = rst;
        @(posedge clk);
        model_step(v, d, r, rst);
        #1;
        compare_outputs();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 21'd0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((m_inflight || m_q.size() > 0) && n < max_cycles) begin
            cycle(1'b0, 21'd0, (m_inflight && m_age >= 1) ? 1'($urandom_range(0, 7) == 0) : 1'b0, 1'b0);
            n++;
        end
        check("drain_bound", 32'(n < max_cycles), 32'(1));
    endtask

    initial begin
        logic [20:0] burst [4];
        int          peak;
        int          n;
        burst[0] = 21'd80000;
        burst[1] = 21'd25000;
        burst[2] = 21'h1F9E58;
        burst[3] = 21'h1EC780;

        // reset state
        cycle(1'b0, 21'd0, 1'b0, 1'b1);
        cycle(1'b0, 21'd0, 1'b0, 1'b1);
        check("rst_srdyi", 32'(srdyi), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));

        // single sample, response at edge 340
        cycle(1'b1, 21'd80000, 1'b0, 1'b0);
        idle_cycle();
        check("single_srdyi_hi", 32'(srdyi), 32'(1));
        check("single_x", 32'(x_adc), 32'(80000));
        idle_cycle();
        check("single_srdyi_lo", 32'(srdyi), 32'(0));
        check("single_busy_wait", 32'(busy), 32'(1));
        for (int e = 4; e < 340; e++) idle_cycle();
        cycle(1'b0, 21'd0, 1'b1, 1'b0);
        check("single_busy_fall", 32'(busy), 32'(0));
        check("single_x_held", 32'(x_adc), 32'(80000));

        // burst of four, peak occupancy 3
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, burst[i], 1'b0, 1'b0);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        check("burst_peak", 32'(peak), 32'(3));
        drain(2000);

        // overflow with NLC silent, then timeout and a full-FIFO pop/push
        cycle(1'b0, 21'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 21'($urandom), 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'(8));
        check("ovf_drop", 32'(drop_cnt), 32'(1));
        n = 0;
        while (m_inflight && n < 2000) begin
            idle_cycle();
            n++;
        end
        check("tmo_bound", 32'(n < 2000), 32'(1));
        check("tmo_cnt", 32'(timeout_cnt), 32'(1));
        check("tmo_idle", 32'(busy), 32'(0));
        cycle(1'b1, 21'($urandom), 1'b0, 1'b0);
        check("full_pop_push_level", 32'(fifo_level), 32'(8));
        check("full_pop_push_drop", 32'(drop_cnt), 32'(1));
        check("full_pop_push_issue", 32'(srdyi), 32'(1));

        // reset during WAIT with three buffered
        cycle(1'b0, 21'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 21'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle_cycle();
        check("pre_rst_level", 32'(fifo_level), 32'(3));
        cycle(1'b0, 21'd0, 1'b0, 1'b1);
        check("mid_rst_x", 32'(x_adc), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_level", 32'(fifo_level), 32'(0));
        cycle(1'b0, 21'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle();
        check("post_rst_no_issue", 32'(busy), 32'(0));

        // random traffic with stray strobes and rare resets
        for (int i = 0; i < 4000; i++)
            cycle(1'($urandom_range(0, 3) == 0), 21'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 999) == 0));
        drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
